// File: rtl/cell_reader_pkg.sv
// Shared screen geometry, board-memory sizing and the pixel-pipeline record
// used by cell_reader and its delay line.
package cell_reader_pkg;

    localparam int SCREEN_WIDTH   = 1024;
    localparam int SCREEN_HEIGHT  = 768;
    localparam int CELL_SHIFT_DEF = 3;
    localparam int WORD_W_DEF     = 16;
    localparam int WORDS_PER_ROW  = (SCREEN_WIDTH >> CELL_SHIFT_DEF) / WORD_W_DEF;
    localparam int CELL_ROWS      = SCREEN_HEIGHT >> CELL_SHIFT_DEF;
    // One extra MSB selects between the two board buffers.
    localparam int ADDR_W         = $clog2(WORDS_PER_ROW * CELL_ROWS) + 1;
    localparam int BIT_W          = $clog2(WORD_W_DEF);

    typedef struct packed {
        logic [10:0]      hcount;
        logic [9:0]       vcount;
        logic [BIT_W-1:0] bit_idx;
        logic             valid;
    } pix_t;

    function automatic logic in_screen(input logic [10:0] h, input logic [9:0] v);
        return (h < 11'(SCREEN_WIDTH)) && (v < 10'(SCREEN_HEIGHT));
    endfunction

endpackage

// File: rtl/cell_reader_delay.sv
// cell_delay: fixed-depth register shift line, used to carry the pixel record
// alongside the board-memory read so it lines up with the returned word.
module cell_delay #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] line_q [DEPTH];

    // Shift the record one stage per clock; reset empties every stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i] <= {W{1'b0}};
            end
        end else begin
            line_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    assign q_o = line_q[DEPTH-1];

endmodule

// File: rtl/cell_reader.sv
// cell_reader: turns the VGA pixel position into board-memory reads and emits
// the cell state aligned with the delayed pixel. Define CELL_READER_GRID_EN to blank grid lines.
module cell_reader
    import cell_reader_pkg::*;
#(
    parameter int CELL_SHIFT = 3,
    parameter int WORD_W     = 16,
    parameter int RD_LAT     = 2
) (
    input  logic              clk_130mhz,
    input  logic              rst_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              buf_sel_in,
    output logic              rd_en_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    input  logic [WORD_W-1:0] rd_data_in,
    output logic [10:0]       hcount_out,
    output logic [9:0]        vcount_out,
    output logic              is_alive_out,
    output logic              frame_start_out
);

    localparam int WPR  = (SCREEN_WIDTH >> CELL_SHIFT) / WORD_W;
    localparam int WA_W = ADDR_W - 1;

    logic [10:0]       col_s;
    logic [9:0]        row_s;
    logic [WA_W-1:0]   word_s;
    logic              in_screen_s;
    logic              frame_first_s;

    logic              buf_d,     buf_q;
    logic              rd_en_d,   rd_en_q;
    logic [ADDR_W-1:0] rd_addr_d, rd_addr_q;
    pix_t              s1_d,      s1_q;

    logic [$bits(pix_t)-1:0] al_vec_s;
    pix_t              al_s;
    logic              grid_s;
    logic              alive_d,   alive_q;
    logic              frame_d,   frame_q;
    logic [10:0]       hcount_q;
    logic [9:0]        vcount_q;

    // Request stage: cell address, bit index and buffer choice for the incoming pixel.
    always_comb begin
        col_s         = hcount_in >> CELL_SHIFT;
        row_s         = vcount_in >> CELL_SHIFT;
        in_screen_s   = in_screen(hcount_in, vcount_in);
        frame_first_s = (hcount_in == 11'd0) && (vcount_in == 10'd0);
        // Pixel (0,0) already reads from the newly chosen buffer.
        buf_d         = frame_first_s ? buf_sel_in : buf_q;
        word_s        = WA_W'(row_s) * WA_W'(WPR) + WA_W'(col_s / 11'(WORD_W));
        rd_en_d       = in_screen_s;
        if (in_screen_s) begin
            rd_addr_d = {buf_d, word_s};
        end else begin
            rd_addr_d = rd_addr_q;
        end
        s1_d         = '0;
        s1_d.hcount  = hcount_in;
        s1_d.vcount  = vcount_in;
        s1_d.bit_idx = col_s[BIT_W-1:0];
        s1_d.valid   = in_screen_s;
    end

    // Register the read strobe/address, the buffer latch and the first pipeline stage.
    always_ff @(posedge clk_130mhz or posedge rst_in) begin
        if (rst_in) begin
            buf_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= {ADDR_W{1'b0}};
            s1_q      <= '0;
        end else begin
            buf_q     <= buf_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            s1_q      <= s1_d;
        end
    end

    cell_delay #(
        .W     ($bits(pix_t)),
        .DEPTH (RD_LAT)
    ) u_delay (
        .clk_i (clk_130mhz),
        .rst_i (rst_in),
        .d_i   (s1_q),
        .q_o   (al_vec_s)
    );

    assign al_s = pix_t'(al_vec_s);

    // Select the cell bit from the returned word for the aligned pixel.
    always_comb begin
`ifdef CELL_READER_GRID_EN
        grid_s = (al_s.hcount[CELL_SHIFT-1:0] == {CELL_SHIFT{1'b0}}) ||
                 (al_s.vcount[CELL_SHIFT-1:0] == {CELL_SHIFT{1'b0}});
`else
        grid_s = 1'b0;
`endif
        alive_d = al_s.valid && !grid_s && rd_data_in[al_s.bit_idx];
        frame_d = al_s.valid && (al_s.hcount == 11'd0) && (al_s.vcount == 10'd0);
    end

    // Output stage register.
    always_ff @(posedge clk_130mhz or posedge rst_in) begin
        if (rst_in) begin
            alive_q  <= 1'b0;
            frame_q  <= 1'b0;
            hcount_q <= 11'd0;
            vcount_q <= 10'd0;
        end else begin
            alive_q  <= alive_d;
            frame_q  <= frame_d;
            hcount_q <= al_s.hcount;
            vcount_q <= al_s.vcount;
        end
    end

    assign rd_en_out       = rd_en_q;
    assign rd_addr_out     = rd_addr_q;
    assign is_alive_out    = alive_q;
    assign frame_start_out = frame_q;
    assign hcount_out      = hcount_q;
    assign vcount_out      = vcount_q;

endmodule

// File: doc/cell_reader.md
CELL_READER -- requirements
Module: cell_reader

Interface
REQ-001 Parameter CELL_SHIFT, default 3: one cell is 2^CELL_SHIFT x 2^CELL_SHIFT pixels.
REQ-002 Parameter WORD_W, default 16: cells per board-memory word, LSB = leftmost cell.
REQ-003 Parameter RD_LAT, default 2: fixed board-memory read latency in cycles.
REQ-004 clk_130mhz  in  1  sole clock, all logic rising-edge.
REQ-005 rst_in  in  1  reset, asynchronous, active-high.
REQ-006 hcount_in  in  11  current pixel column from VGA timing.
REQ-007 vcount_in  in  10  current pixel row from VGA timing.
REQ-008 buf_sel_in  in  1  board buffer to display (double-buffered board).
REQ-009 rd_en_out  out  1  board-memory read strobe.
REQ-010 rd_addr_out  out  ADDR_W  word address; MSB = latched buffer select.
REQ-011 rd_data_in  in  WORD_W  word returned RD_LAT cycles after rd_en_out.
REQ-012 hcount_out  out  11  hcount_in delayed to align with is_alive_out.
REQ-013 vcount_out  out  10  vcount_in delayed to align with is_alive_out.
REQ-014 is_alive_out  out  1  state of the cell under the delayed pixel.
REQ-015 frame_start_out  out  1  one-cycle pulse aligned with delayed pixel (0,0).

Function
REQ-016 Pipeline latency hcount_in/vcount_in -> hcount_out/vcount_out/is_alive_out SHALL be exactly RD_LAT+2 cycles (4 by default), independent of pixel position.
REQ-017 Cell coords: col = hcount_in >> CELL_SHIFT, row = vcount_in >> CELL_SHIFT.
REQ-018 Word address = {buf_latched, row * WORDS_PER_ROW + col / WORD_W}; WORDS_PER_ROW = (SCREEN_WIDTH >> CELL_SHIFT) / WORD_W (8 by default).
REQ-019 rd_en_out SHALL assert only for in-screen pixels (hcount_in < SCREEN_WIDTH and vcount_in < SCREEN_HEIGHT), registered one cycle after the pixel.
REQ-020 Output bit index = col mod WORD_W, carried through the pipeline with the pixel, selected from rd_data_in in the final stage.
REQ-021 Out-of-screen pixels SHALL yield is_alive_out = 0 regardless of rd_data_in.
REQ-022 buf_sel_in SHALL be sampled only when hcount_in == 0 and vcount_in == 0; the buffer select is never changed mid-frame.
REQ-023 Pipeline stage valid bits SHALL track in-screen status; no output depends on an unrequested read.
REQ-024 hcount/vcount wrap (last pixel -> 0,0) SHALL need no special handling; consecutive frames stream with no bubbles.

Reset
REQ-025 While rst_in is high: rd_en_out, is_alive_out, frame_start_out = 0; hcount_out, vcount_out, rd_addr_out = 0; buffer select latch = 0; all pipeline valid bits cleared.
REQ-026 After rst_in deasserts mid-frame, outputs SHALL be valid for pixels entering from the next cycle on (valid after RD_LAT+2 cycles); buffer select stays 0 until the next (0,0).

Configuration
REQ-027 Macro CELL_READER_GRID_EN: when defined, pixels whose hcount or vcount low CELL_SHIFT bits are all zero SHALL output is_alive_out = 0 (grid lines); when undefined, every pixel of a cell reports the cell state. Latency unchanged in both cases.

Structure
REQ-028 SCREEN_WIDTH, SCREEN_HEIGHT, WORD_W default, derived WORDS_PER_ROW, ADDR_W and a pixel-pipeline struct (hcount, vcount, bit index, valid) SHALL live in the shared package (common.svh).
REQ-029 One sub-module cell_delay (parameterised-width, parameterised-depth register shift line with async reset) SHALL carry the pixel struct through the pipeline.

Verification
REQ-030 Reset pulse, then pixel (0,0) with buf_sel_in=1 -> rd_en_out=1, rd_addr_out MSB=1, word 0 one cycle later; hcount_out/vcount_out = 0,0 and frame_start_out=1 four cycles after input.
REQ-031 Memory model returns 16'h0001 for word 0 -> is_alive_out=1 for hcount 0..7 of rows 0..7, 0 for hcount 8..127.
REQ-032 hcount_in=1030, vcount_in=100 with rd_data_in all ones -> rd_en_out=0, is_alive_out=0.
REQ-033 buf_sel_in toggled at hcount 500 mid-frame -> rd_addr_out MSB unchanged until the next (0,0), then follows new value.
REQ-034 Full frame checkerboard pattern, alternating is_alive per cell -> every output pixel matches reference model at 4-cycle offset; with CELL_READER_GRID_EN, pixels with hcount[2:0]==0 or vcount[2:0]==0 read 0.
REQ-035 rst_in asserted for 1 cycle mid-row -> all outputs 0 immediately (asynchronous), correct stream resumes 4 cycles after release.
